// File: rtl/pong_pkg.sv
// Shared constants and serve-FSM state encoding for the pong game logic.
package pong_pkg;

  localparam int SCREEN_H_DEF = 768;
  localparam int PADDLE_H_DEF = 96;
  localparam int STATE_W      = 2;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT_REL = 2'd0,
    S_ARMED    = 2'd1,
    S_DEBOUNCE = 2'd2
  } serve_state_t;

endpackage

// File: rtl/paddle_serve_fsm.sv
// Frame-based debounce of the serve button; emits a single-cycle serve_pulse.
module paddle_serve_fsm
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic button,
  input  logic serve_enable,
  output logic serve_pulse
);

  localparam logic [3:0] LAST_CNT = 4'(DEBOUNCE_FRAMES);

  serve_state_t state;
  logic [3:0]   cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_WAIT_REL;
      cnt         <= '0;
      serve_pulse <= 1'b0;
    end else begin
      serve_pulse <= 1'b0;
      case (state)
        S_WAIT_REL: begin
          if (frame_tick && !button) state <= S_ARMED;
        end
        S_ARMED: begin
          if (frame_tick && button && serve_enable) begin
            if (DEBOUNCE_FRAMES == 1) begin
              serve_pulse <= 1'b1;
              state       <= S_WAIT_REL;
            end else begin
              state <= S_DEBOUNCE;
              cnt   <= 4'd1;
            end
          end
        end
        S_DEBOUNCE: begin
          // Losing serve_enable aborts on any cycle, not only on a tick.
          if (!serve_enable) begin
            state <= S_ARMED;
            cnt   <= '0;
          end else if (frame_tick) begin
            if (!button) begin
              state <= S_ARMED;
              cnt   <= '0;
            end else if (cnt + 4'd1 == LAST_CNT) begin
              serve_pulse <= 1'b1;
              state       <= S_WAIT_REL;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= S_WAIT_REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Player paddle: clamps mouse y to the playfield and moves once per frame.
// PADDLE_SLEW_EN defined: move limited to +/-MAX_STEP; undefined: jump to target.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H        = SCREEN_H_DEF,
  parameter int PADDLE_H        = PADDLE_H_DEF,
  parameter int MAX_STEP        = 16,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [11:0] ypos_in,
  input  logic        mouse_left_in,
  input  logic        serve_enable,
  output logic [11:0] paddle_y,
  output logic [7:0]  paddle_vel,
  output logic        serve_pulse
);

  localparam int               Y_MAX   = SCREEN_H - PADDLE_H;
  localparam logic [11:0]      Y_RST   = 12'(Y_MAX / 2);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
  localparam logic signed [12:0] HALF_S  = 13'(PADDLE_H / 2);

  logic signed [12:0] target_raw;
  logic [11:0]        target;
  logic signed [12:0] delta;
  logic [11:0]        next_y;
  logic [7:0]         next_vel;

`ifdef PADDLE_SLEW_EN
  localparam logic signed [12:0] STEP_S = 13'(MAX_STEP);
  logic signed [12:0] step;
`endif

  // 13-bit signed so that ypos_in up to 4095 and below PADDLE_H/2 both clamp correctly.
  assign target_raw = signed'({1'b0, ypos_in}) - HALF_S;
  assign delta      = signed'({1'b0, target}) - signed'({1'b0, paddle_y});

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    target   = target_raw[11:0];
    next_y   = paddle_y;
    next_vel = '0;
    if (target_raw < 0)             target = '0;
    else if (target_raw > Y_MAX_S)  target = Y_MAX_S[11:0];
`ifdef PADDLE_SLEW_EN
    step = delta;
    if (delta > STEP_S)        step = STEP_S;
    else if (delta < -STEP_S)  step = -STEP_S;
    next_y   = paddle_y + step[11:0];
    next_vel = step[7:0];
`else
    next_y   = target;
    next_vel = delta[7:0];
    if (delta > 13'sd127)       next_vel = 8'sd127;
    else if (delta < -13'sd127) next_vel = -8'sd127;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddle_y   <= Y_RST;
      paddle_vel <= '0;
    end else if (frame_tick) begin
      paddle_y   <= next_y;
      paddle_vel <= next_vel;
    end
  end

  paddle_serve_fsm #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_serve (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .button       (mouse_left_in),
    .serve_enable (serve_enable),
    .serve_pulse  (serve_pulse)
  );

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl; expectations follow PADDLE_SLEW_EN.
module tb_paddle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [11:0] ypos_in = '0;
  logic        mouse_left_in = 1'b0;
  logic        serve_enable = 1'b1;
  logic [11:0] paddle_y;
  logic [7:0]  paddle_vel;
  logic        serve_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;

  paddle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .ypos_in       (ypos_in),
    .mouse_left_in (mouse_left_in),
    .serve_enable  (serve_enable),
    .paddle_y      (paddle_y),
    .paddle_vel    (paddle_vel),
    .serve_pulse   (serve_pulse)
  );

  always #8 clk = ~clk;

  always @(posedge clk) if (serve_pulse === 1'b1) pulse_count <= pulse_count + 1;

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic do_tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic tick_check(input string tag, input int exp_y, input int exp_vel);
    do_tick();
    check({tag, "_y"}, paddle_y, exp_y);
    check({tag, "_vel"}, $signed(paddle_vel), exp_vel);
  endtask

  initial begin
    // Reset held across several frame ticks.
    repeat (2) @(negedge clk);
    repeat (5) do_tick();
    check("rst_y", paddle_y, 336);
    check("rst_vel", $signed(paddle_vel), 0);
    check("rst_pulse", serve_pulse, 0);

    // Button pressed while still in reset, held through release.
    mouse_left_in = 1'b1;
    ypos_in = 12'd400;
    @(negedge clk) rst = 1'b0;

    tick_check("up1", 352, 16);
    tick_check("hold", 352, 0);

    ypos_in = 12'd10;
`ifdef PADDLE_SLEW_EN
    for (int i = 1; i <= 22; i++) tick_check("down", 352 - 16 * i, -16);
`else
    tick_check("down", 0, -127);
`endif
    tick_check("down_end", 0, 0);

    ypos_in = 12'd47;
    tick_check("tgt_neg", 0, 0);

    ypos_in = 12'd4000;
`ifdef PADDLE_SLEW_EN
    for (int i = 1; i <= 42; i++) tick_check("climb", 16 * i, 16);
`else
    tick_check("climb", 672, 127);
`endif
    tick_check("climb_end", 672, 0);

    ypos_in = 12'd4095;
    tick_check("tgt_max", 672, 0);

    check("held_no_serve", pulse_count, 0);

    // Release one tick, then press three ticks: one serve.
    mouse_left_in = 1'b0;
    do_tick();
    mouse_left_in = 1'b1;
    do_tick();
    do_tick();
    check("press2_no_pulse", serve_pulse, 0);
    do_tick();
    check("press3_pulse", serve_pulse, 1);
    @(negedge clk);
    check("pulse_width", serve_pulse, 0);
    check("pulse_count1", pulse_count, 1);
    repeat (4) do_tick();
    check("keep_hold", pulse_count, 1);

    // Short press: two ticks then release.
    mouse_left_in = 1'b0;
    do_tick();
    mouse_left_in = 1'b1;
    do_tick();
    do_tick();
    mouse_left_in = 1'b0;
    do_tick();
    check("short_press", pulse_count, 1);

    // serve_enable drops during debounce: abort back to armed.
    mouse_left_in = 1'b1;
    do_tick();
    @(negedge clk) serve_enable = 1'b0;
    @(negedge clk);
    do_tick();
    check("abort_no_pulse", pulse_count, 1);
    serve_enable = 1'b1;
    do_tick();
    do_tick();
    check("rearm_2ticks", pulse_count, 1);
    do_tick();
    check("rearm_pulse", serve_pulse, 1);
    @(negedge clk);
    check("rearm_count", pulse_count, 2);

    // Mid-debounce reset drops the pending serve and recentres the paddle.
    mouse_left_in = 1'b0;
    do_tick();
    mouse_left_in = 1'b1;
    do_tick();
    do_tick();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("midrst_y", paddle_y, 336);
    check("midrst_vel", $signed(paddle_vel), 0);
    rst = 1'b0;
    ypos_in = 12'd1000;
`ifdef PADDLE_SLEW_EN
    tick_check("jump", 352, 16);
`else
    tick_check("jump", 672, 127);
`endif
    check("midrst_no_pulse", serve_pulse, 0);

    // Three back-to-back ticks each count.
    @(negedge clk) frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
`ifdef PADDLE_SLEW_EN
    check("consec_y", paddle_y, 400);
    check("consec_vel", $signed(paddle_vel), 16);
`else
    check("consec_y", paddle_y, 672);
    check("consec_vel", $signed(paddle_vel), 0);
`endif
    @(negedge clk);
    check("final_count", pulse_count, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
